// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the multi-cycle controller and the
// instruction/data memories.
//
// Handshake: a request (o_imem_req / o_dmem_req) is raised by the controller
// and held steady, together with o_dmem_we, until the memory answers with the
// matching ready in the same cycle. The transfer completes on the rising clock
// edge where req and ready are both high. Ready is ignored while req is low.
//
// Signals:
//   o_imem_req   controller -> imem  instruction fetch request
//   i_imem_ready imem -> controller  instruction fetch acknowledge
//   o_dmem_req   controller -> dmem  data access request
//   o_dmem_we    controller -> dmem  write qualifier, valid with o_dmem_req
//   i_dmem_ready dmem -> controller  data access acknowledge
interface multicycle_ctrl_if;
  logic o_imem_req;
  logic i_imem_ready;
  logic o_dmem_req;
  logic o_dmem_we;
  logic i_dmem_ready;

  modport master (
    output o_imem_req,
    output o_dmem_req,
    output o_dmem_we,
    input  i_imem_ready,
    input  i_dmem_ready
  );

  modport slave (
    input  o_imem_req,
    input  o_dmem_req,
    input  o_dmem_we,
    output i_imem_ready,
    output i_dmem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing FSM for the 18-bit core. Steps the datapath through
// FETCH, DECODE, EXEC, MEM and WB using the decoder control bits, handshakes
// with instruction/data memory, guards every memory wait with a watchdog and
// counts retired instructions.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_run                   leave IDLE / keep fetching while high
//   i_pc_src .. i_regWrite  decoder control bits for the instruction in IR
//   i_alu_zero              ALU zero flag, sampled in EXEC
//   mem                     memory handshake bundle (controller side)
//   o_ir_we, o_mdr_we       IR / MDR load strobes
//   o_rf_we, o_pc_we        register file / PC write strobes
//   o_pc_sel                00 PC+1, 01 branch target, 10 jump target
//   o_state                 current state encoding
//   o_fault                 sticky fault flag
//   o_retired               completed instruction count (wraps)
module multicycle_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4,
  parameter int RET_W    = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_run,
  input  logic               i_pc_src,
  input  logic               i_branch,
  input  logic               i_memRead,
  input  logic               i_memWrite,
  input  logic               i_regWrite,
  input  logic               i_alu_zero,
  multicycle_ctrl_if.master  mem,
  output logic               o_ir_we,
  output logic               o_mdr_we,
  output logic               o_rf_we,
  output logic               o_pc_we,
  output logic [1:0]         o_pc_sel,
  output logic [2:0]         o_state,
  output logic               o_fault,
  output logic [RET_W-1:0]   o_retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  localparam logic [1:0]        PC_NEXT   = 2'b00;
  localparam logic [1:0]        PC_BRANCH = 2'b01;
  localparam logic [1:0]        PC_JUMP   = 2'b10;
  localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_MAX[WAIT_W-1:0];
  localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [RET_W-1:0]  RET_ONE   = {{(RET_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [RET_W-1:0]  retired_q, retired_d;
  logic              fault_q, fault_d;

  logic imem_req, dmem_req, dmem_we;
  logic ir_we, mdr_we, rf_we, pc_we;
  logic [1:0] pc_sel;
  logic retire;

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;      // anything but a held request clears the watchdog
    retired_d = retired_q;
    fault_d   = fault_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    mdr_we    = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_NEXT;
    retire    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_run) state_d = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (mem.i_imem_ready) begin
          // Ready wins even when the watchdog sits at its limit.
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LIM) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end

      S_DECODE: begin
        state_d = S_EXEC;
      end

      S_EXEC: begin
        if (i_memRead && i_memWrite) begin
          state_d = S_FAULT;
        end else if (i_pc_src) begin
          pc_sel = PC_JUMP;
          retire = 1'b1;
        end else if (i_branch) begin
          // BNE: taken when the ALU result is non-zero.
          pc_sel = i_alu_zero ? PC_NEXT : PC_BRANCH;
          retire = 1'b1;
        end else if (i_memRead || i_memWrite) begin
          state_d = S_MEM;
        end else if (i_regWrite) begin
          state_d = S_WB;
        end else begin
          retire = 1'b1;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = i_memWrite;
        if (mem.i_dmem_ready) begin
          if (i_memRead) begin
            mdr_we  = 1'b1;
            state_d = S_WB;
          end else begin
            retire = 1'b1;
          end
        end else if (wait_q == WAIT_LIM) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end

      S_WB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_FAULT;
      end
    endcase

    // i_run is only consulted here, so an instruction in flight always finishes.
    if (retire) begin
      pc_we     = 1'b1;
      retired_d = retired_q + RET_ONE;
      state_d   = i_run ? S_FETCH : S_IDLE;
    end

    if (state_d == S_FAULT) fault_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
    end
  end

  assign mem.o_imem_req = imem_req;
  assign mem.o_dmem_req = dmem_req;
  assign mem.o_dmem_we  = dmem_we;
  assign o_ir_we        = ir_we;
  assign o_mdr_we       = mdr_we;
  assign o_rf_we        = rf_we;
  assign o_pc_we        = pc_we;
  assign o_pc_sel       = pc_sel;
  assign o_state        = state_q;
  assign o_fault        = fault_q;
  assign o_retired      = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (WAIT_MAX=15, RET_W=4 so the retire
// counter wrap is reachable). Inputs change 1 time unit after the rising
// edge; outputs are checked 1 unit later, well away from the next edge.
module tb_multicycle_ctrl;

  localparam int RET_W = 4;

  logic i_clk;
  logic i_rst_n;
  logic i_run, i_pc_src, i_branch, i_memRead, i_memWrite, i_regWrite, i_alu_zero;
  logic o_ir_we, o_mdr_we, o_rf_we, o_pc_we, o_fault;
  logic [1:0] o_pc_sel;
  logic [2:0] o_state;
  logic [RET_W-1:0] o_retired;

  int tests_run;
  int tests_failed;

  multicycle_ctrl_if mif ();

  multicycle_ctrl #(
    .WAIT_MAX (15),
    .WAIT_W   (4),
    .RET_W    (RET_W)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_run      (i_run),
    .i_pc_src   (i_pc_src),
    .i_branch   (i_branch),
    .i_memRead  (i_memRead),
    .i_memWrite (i_memWrite),
    .i_regWrite (i_regWrite),
    .i_alu_zero (i_alu_zero),
    .mem        (mif),
    .o_ir_we    (o_ir_we),
    .o_mdr_we   (o_mdr_we),
    .o_rf_we    (o_rf_we),
    .o_pc_we    (o_pc_we),
    .o_pc_sel   (o_pc_sel),
    .o_state    (o_state),
    .o_fault    (o_fault),
    .o_retired  (o_retired)
  );

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // driver tasks
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_dec(input logic pc_src, input logic branch, input logic rd,
                         input logic wr, input logic rw, input logic zero);
    i_pc_src   = pc_src;
    i_branch   = branch;
    i_memRead  = rd;
    i_memWrite = wr;
    i_regWrite = rw;
    i_alu_zero = zero;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One NOP from FETCH (imem_ready=1) back to the next FETCH.
  task automatic run_nop();
    set_dec(0, 0, 0, 0, 0, 0);
    step(); // DECODE
    step(); // EXEC, retires
    step(); // FETCH
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    i_rst_n = 1'b0;
    i_run   = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0);
    mif.i_imem_ready = 1'b0;
    mif.i_dmem_ready = 1'b0;

    // ---------------- reset state
    settle();
    check("rst_state",   32'(o_state), 32'd0);
    check("rst_fault",   32'(o_fault), 32'd0);
    check("rst_retired", 32'(o_retired), 32'd0);
    check("rst_imem_req", 32'(mif.o_imem_req), 32'd0);
    check("rst_pc_we",   32'(o_pc_we), 32'd0);
    check("rst_pc_sel",  32'(o_pc_sel), 32'd0);
    step();
    step();
    i_rst_n = 1'b1;
    step();
    check("idle_hold", 32'(o_state), 32'd0);

    // ---------------- NOP stream
    i_run = 1'b1;
    mif.i_imem_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("nop_fetch_state", 32'(o_state), 32'd1);
      check("nop_fetch_ir_we", 32'(o_ir_we), 32'd1);
      check("nop_fetch_req",   32'(mif.o_imem_req), 32'd1);
      step();
      check("nop_decode_state", 32'(o_state), 32'd2);
      check("nop_decode_pc_we", 32'(o_pc_we), 32'd0);
      step();
      check("nop_exec_state",  32'(o_state), 32'd3);
      check("nop_exec_pc_we",  32'(o_pc_we), 32'd1);
      check("nop_exec_pc_sel", 32'(o_pc_sel), 32'd0);
      step();
    end
    check("nop_retired3", 32'(o_retired), 32'd3);

    // ---------------- load with 2 cycles of dmem wait
    set_dec(0, 0, 1, 0, 1, 0);
    step(); // DECODE
    step(); // EXEC
    settle();
    check("ld_exec_pc_we", 32'(o_pc_we), 32'd0);
    step(); // MEM 1
    check("ld_mem1_state", 32'(o_state), 32'd4);
    check("ld_mem1_req",   32'(mif.o_dmem_req), 32'd1);
    check("ld_mem1_we",    32'(mif.o_dmem_we), 32'd0);
    check("ld_mem1_mdr",   32'(o_mdr_we), 32'd0);
    step(); // MEM 2
    check("ld_mem2_req", 32'(mif.o_dmem_req), 32'd1);
    step(); // MEM 3, ready
    mif.i_dmem_ready = 1'b1;
    settle();
    check("ld_mem3_req", 32'(mif.o_dmem_req), 32'd1);
    check("ld_mem3_mdr", 32'(o_mdr_we), 32'd1);
    check("ld_mem3_rf",  32'(o_rf_we), 32'd0);
    step(); // WB
    mif.i_dmem_ready = 1'b0;
    settle();
    check("ld_wb_state", 32'(o_state), 32'd5);
    check("ld_wb_rf",    32'(o_rf_we), 32'd1);
    check("ld_wb_mdr",   32'(o_mdr_we), 32'd0);
    check("ld_wb_pc_we", 32'(o_pc_we), 32'd1);
    check("ld_wb_req",   32'(mif.o_dmem_req), 32'd0);
    step(); // FETCH
    check("ld_retired", 32'(o_retired), 32'd4);

    // ---------------- BNE not zero -> taken
    set_dec(0, 1, 0, 0, 0, 0);
    step();
    step();
    settle();
    check("bne_nz_pc_sel", 32'(o_pc_sel), 32'd1);
    check("bne_nz_pc_we",  32'(o_pc_we), 32'd1);
    check("bne_nz_rf",     32'(o_rf_we), 32'd0);
    step();
    check("bne_nz_retired", 32'(o_retired), 32'd5);

    // ---------------- BNE zero -> fall through
    set_dec(0, 1, 0, 0, 0, 1);
    step();
    step();
    settle();
    check("bne_z_pc_sel", 32'(o_pc_sel), 32'd0);
    check("bne_z_pc_we",  32'(o_pc_we), 32'd1);
    step();

    // ---------------- JMP
    set_dec(1, 0, 0, 0, 0, 0);
    step();
    step();
    settle();
    check("jmp_pc_sel", 32'(o_pc_sel), 32'd2);
    check("jmp_pc_we",  32'(o_pc_we), 32'd1);
    check("jmp_rf",     32'(o_rf_we), 32'd0);
    step();
    check("jmp_retired", 32'(o_retired), 32'd7);

    // ---------------- ALU with register write (4 cycles)
    set_dec(0, 0, 0, 0, 1, 0);
    step();
    step();
    settle();
    check("alu_exec_pc_we", 32'(o_pc_we), 32'd0);
    step();
    check("alu_wb_state", 32'(o_state), 32'd5);
    check("alu_wb_rf",    32'(o_rf_we), 32'd1);
    check("alu_wb_pc_we", 32'(o_pc_we), 32'd1);
    step();
    check("alu_retired", 32'(o_retired), 32'd8);

    // ---------------- store, i_run dropped during MEM
    set_dec(0, 0, 0, 1, 0, 0);
    step();
    step();
    step(); // MEM 1
    i_run = 1'b0;
    settle();
    check("st_mem_state", 32'(o_state), 32'd4);
    check("st_mem_we",    32'(mif.o_dmem_we), 32'd1);
    check("st_mem_pc_we", 32'(o_pc_we), 32'd0);
    step(); // MEM 2, ready
    mif.i_dmem_ready = 1'b1;
    settle();
    check("st_ready_pc_we",  32'(o_pc_we), 32'd1);
    check("st_ready_pc_sel", 32'(o_pc_sel), 32'd0);
    check("st_ready_mdr",    32'(o_mdr_we), 32'd0);
    step();
    mif.i_dmem_ready = 1'b0;
    check("st_idle_state", 32'(o_state), 32'd0);
    check("st_idle_req",   32'(mif.o_imem_req), 32'd0);
    check("st_retired",    32'(o_retired), 32'd9);
    step();
    check("st_idle_stay", 32'(o_state), 32'd0);

    // ---------------- retire counter wrap (9 -> 15 -> 0)
    i_run = 1'b1;
    step(); // FETCH
    for (int i = 0; i < 6; i++) run_nop();
    check("wrap_15", 32'(o_retired), 32'd15);
    run_nop();
    check("wrap_0", 32'(o_retired), 32'd0);

    // ---------------- illegal decode -> FAULT, absorbing
    set_dec(0, 0, 1, 1, 0, 0);
    step();
    step();
    check("ill_exec_state", 32'(o_state), 32'd3);
    check("ill_exec_pc_we", 32'(o_pc_we), 32'd0);
    step();
    check("ill_state", 32'(o_state), 32'd6);
    check("ill_fault", 32'(o_fault), 32'd1);
    check("ill_req",   32'(mif.o_imem_req), 32'd0);
    step();
    check("ill_absorb_state", 32'(o_state), 32'd6);
    check("ill_absorb_pc_we", 32'(o_pc_we), 32'd0);

    // ---------------- async reset mid-FETCH
    i_rst_n = 1'b0;
    settle();
    i_rst_n = 1'b1;
    set_dec(0, 0, 0, 0, 0, 0);
    mif.i_imem_ready = 1'b0;
    step(); // IDLE -> FETCH
    step(); // FETCH held
    check("ar_fetch_req", 32'(mif.o_imem_req), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("ar_req_drop", 32'(mif.o_imem_req), 32'd0);
    check("ar_state",    32'(o_state), 32'd0);
    check("ar_retired",  32'(o_retired), 32'd0);
    check("ar_fault",    32'(o_fault), 32'd0);
    step();
    i_rst_n = 1'b1;

    // ---------------- watchdog: imem never ready -> FAULT after 16 FETCH cycles
    step(); // FETCH cycle 1
    for (int i = 1; i < 16; i++) begin
      check("wd_fetch_state", 32'(o_state), 32'd1);
      step();
    end
    check("wd_c16_state", 32'(o_state), 32'd1);
    check("wd_c16_req",   32'(mif.o_imem_req), 32'd1);
    check("wd_c16_fault", 32'(o_fault), 32'd0);
    step();
    check("wd_fault_state", 32'(o_state), 32'd6);
    check("wd_fault_flag",  32'(o_fault), 32'd1);
    check("wd_fault_req",   32'(mif.o_imem_req), 32'd0);

    // ---------------- watchdog: ready on 16th cycle wins
    i_rst_n = 1'b0;
    settle();
    i_rst_n = 1'b1;
    step(); // FETCH cycle 1
    for (int i = 1; i < 16; i++) step();
    mif.i_imem_ready = 1'b1;
    settle();
    check("wd_win_state", 32'(o_state), 32'd1);
    check("wd_win_ir_we", 32'(o_ir_we), 32'd1);
    step();
    check("wd_win_decode", 32'(o_state), 32'd2);
    check("wd_win_fault",  32'(o_fault), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
